// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: divide-sequencer state encoding,
//                the R-type funct code for div, and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Divide sequencer states (2-bit encoding)
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    // R-type funct field that selects the divide instruction
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    // Default operand/result width of the CPU datapath
    localparam int DIV_WIDTH_DEFAULT = 32;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/div_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step. Shifts the next
//                dividend bit into the partial remainder and subtracts the
//                divisor if it fits, yielding one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_next,
    output logic             o_q_bit
);

    // The partial remainder is always below the divisor, so a WIDTH+1 bit
    // trial difference is wide enough for its sign bit to be exact.
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Trial subtraction and restore decision
    always_comb begin
        w_shifted  = {i_rem, i_dvd_msb};
        w_trial    = w_shifted - {1'b0, i_divisor};
        o_q_bit    = ~w_trial[WIDTH];
        o_rem_next = o_q_bit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_ctrl
//  Description : Multi-cycle divide sequencer for the CPU div instruction.
//                Stalls the pipeline while a restoring divider produces one
//                quotient bit per clock, then presents quotient/remainder for
//                a single write-back cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH_DEFAULT,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div0
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    div_state_t         r_state;
    div_state_t         w_state_next;

    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dvs;      // latched divisor magnitude
    logic [c_cnt_w-1:0] r_cnt;      // steps remaining
    logic               r_qsign;
    logic               r_rsign;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_q_final;
    logic               w_last;

    // Operand conditioning: magnitudes for signed divide, raw values otherwise
    always_comb begin
        w_a_neg   = SIGNED & a[WIDTH-1];
        w_b_neg   = SIGNED & b[WIDTH-1];
        w_a_mag   = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag   = w_b_neg ? (~b + 1'b1) : b;
        w_b_zero  = (b == '0);
        w_q_final = {r_dvd[WIDTH-2:0], w_q_bit};
        w_last    = (r_cnt == c_cnt_w'(1));
    end

    div_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .i_rem      (r_rem),
        .i_dvd_msb  (r_dvd[WIDTH-1]),
        .i_divisor  (r_dvs),
        .o_rem_next (w_rem_next),
        .o_q_bit    (w_q_bit)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and pipeline stall request
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                stall = start;
                if (start) begin
                    w_state_next = w_b_zero ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                stall = 1'b1;
                if (w_last) begin
                    w_state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                // The div instruction retires now; start is ignored.
                w_state_next = DIV_IDLE;
            end
            default: begin
                w_state_next = DIV_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_busy <= (w_state_next == DIV_RUN);
            r_done <= (w_state_next == DIV_DONE);
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        if (w_b_zero) begin
                            r_q    <= '1;
                            r_r    <= a;
                            r_div0 <= 1'b1;
                        end else begin
                            r_div0  <= 1'b0;
                            r_rem   <= '0;
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_qsign <= w_a_neg ^ w_b_neg;
                            r_rsign <= w_a_neg;
                            r_cnt   <= c_cnt_w'(WIDTH);
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_q_final;
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (w_last) begin
                        // Remainder follows the dividend's sign.
                        r_q <= r_qsign ? (~w_q_final + 1'b1) : w_q_final;
                        r_r <= r_rsign ? (~w_rem_next + 1'b1) : w_rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;
    assign div0 = r_div0;

endmodule : div_seq_ctrl
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq_ctrl
//  Description : Self-checking bench for div_seq_ctrl, signed and unsigned
//                instances driven in parallel against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a_in  = '0;
    logic [W-1:0]  b_in  = '0;

    logic          stall_s, busy_s, done_s, div0_s;
    logic [W-1:0]  q_s, r_s;
    logic          stall_u, busy_u, done_u, div0_u;
    logic [W-1:0]  q_u, r_u;

    div_seq_ctrl #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .clock (clock), .reset (reset), .start (start), .a (a_in), .b (b_in),
        .stall (stall_s), .busy (busy_s), .done (done_s),
        .q (q_s), .r (r_s), .div0 (div0_s)
    );

    div_seq_ctrl #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
        .clock (clock), .reset (reset), .start (start), .a (a_in), .b (b_in),
        .stall (stall_u), .busy (busy_u), .done (done_u),
        .q (q_u), .r (r_u), .div0 (div0_u)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: 64-bit signed division truncates toward zero and
    // gives the remainder the dividend's sign; the low word is the answer.
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] qs, output logic [W-1:0] rs,
                                    output logic [W-1:0] qu, output logic [W-1:0] ru,
                                    output logic dz);
        longint sx, sy;
        if (y == '0) begin
            qs = '1; rs = x; qu = '1; ru = x; dz = 1'b1;
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            qs = W'(sx / sy);
            rs = W'(sx % sy);
            qu = x / y;
            ru = x % y;
            dz = 1'b0;
        end
    endfunction

    // Behavioural model: an accepted op completes WIDTH+1 cycles later
    // (1 cycle for a zero divisor); the following cycle is idle again.
    bit            m_armed = 1'b0;
    bit            m_on    = 1'b0;
    int            m_phase = 0;
    int            m_done_at = 0;
    logic [W-1:0]  m_qs, m_rs, m_qu, m_ru;
    logic          m_dz;

    always @(posedge clock) begin
        if (reset) begin
            m_on    = 1'b0;
            m_armed = 1'b1;
        end else if (m_on && m_phase == m_done_at) begin
            m_on = 1'b0;
        end else if (m_on) begin
            m_phase++;
        end else if (start) begin
            m_on      = 1'b1;
            m_phase   = 1;
            m_done_at = (b_in == '0) ? 1 : W + 1;
            ref_div(a_in, b_in, m_qs, m_rs, m_qu, m_ru, m_dz);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        logic e_done, e_busy, e_stall;
        if (m_armed) begin
            e_done  = m_on && (m_phase == m_done_at);
            e_busy  = m_on && !e_done;
            e_stall = e_busy || (!m_on && start);
            check("busy_s",  W'(busy_s),  W'(e_busy));
            check("done_s",  W'(done_s),  W'(e_done));
            check("stall_s", W'(stall_s), W'(e_stall));
            check("busy_u",  W'(busy_u),  W'(e_busy));
            check("done_u",  W'(done_u),  W'(e_done));
            check("stall_u", W'(stall_u), W'(e_stall));
            if (e_done) begin
                check("q_s",    q_s,         m_qs);
                check("r_s",    r_s,         m_rs);
                check("div0_s", W'(div0_s),  W'(m_dz));
                check("q_u",    q_u,         m_qu);
                check("r_u",    r_u,         m_ru);
                check("div0_u", W'(div0_u),  W'(m_dz));
            end
        end
    end

    // Issue one divide; operands are scrambled after acceptance.
    task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep,
                          output logic [W-1:0] qs, output logic [W-1:0] rs,
                          output logic [W-1:0] qu, output logic [W-1:0] ru,
                          output logic dz, output int lat, output int nstall,
                          output int nbusy);
        bit seen;
        @(posedge clock); #2;
        a_in = x; b_in = y; start = 1'b1;
        lat = 0; nstall = 0; nbusy = 0; seen = 1'b0;
        qs = '0; rs = '0; qu = '0; ru = '0; dz = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (stall_s) nstall++;
            if (busy_s)  nbusy++;
            if (done_s) begin
                seen = 1'b1;
                qs = q_s; rs = r_s; qu = q_u; ru = r_u; dz = div0_s;
                break;
            end
            @(posedge clock); #2;
            lat++;
            a_in = $urandom; b_in = $urandom;
        end
        if (!seen) check("done_timeout", W'(done_s), W'(1));
        if (!keep) begin
            @(posedge clock); #2;
            start = 1'b0;
        end
    endtask

    logic [W-1:0] qs, rs, qu, ru, x, y;
    logic         dz;
    int           lat, nstall, nbusy, ndone;

    initial begin
        // Reset state
        @(posedge clock); #2;
        @(negedge clock);
        check("rst_q",    q_s, 32'h0);
        check("rst_r",    r_s, 32'h0);
        check("rst_div0", W'(div0_s), 32'h0);
        @(posedge clock); #2;
        reset = 1'b0;

        // 100 / 7
        do_div(32'd100, 32'd7, 1'b0, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("t1_q", qs, 32'd14);
        check("t1_r", rs, 32'd2);
        check("t1_div0", W'(dz), 32'd0);
        check("t1_lat", W'(lat), 32'd33);
        check("t1_stall_cycles", W'(nstall), 32'd33);

        // -100 / 7 and -100 / -7
        do_div(32'hFFFFFF9C, 32'd7, 1'b0, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("t2_q", qs, 32'hFFFFFFF2);
        check("t2_r", rs, 32'hFFFFFFFE);
        do_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("t3_q", qs, 32'd14);
        check("t3_r", rs, 32'hFFFFFFFE);

        // Most-negative / -1 wraps; unsigned view of the same operands
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b0, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("t4_qs", qs, 32'h80000000);
        check("t4_rs", rs, 32'h0);
        check("t4_qu", qu, 32'h0);
        check("t4_ru", ru, 32'h80000000);

        // Divide by zero
        do_div(32'd5, 32'd0, 1'b0, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("t5_lat",  W'(lat), 32'd1);
        check("t5_q",    qs, 32'hFFFFFFFF);
        check("t5_r",    rs, 32'd5);
        check("t5_div0", W'(dz), 32'd1);
        check("t5_busy_cycles", W'(nbusy), 32'd0);

        // Reset in the middle of RUN
        @(posedge clock); #2;
        a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
        repeat (10) begin
            @(posedge clock); #2;
            a_in = $urandom; b_in = $urandom;
        end
        reset = 1'b1; start = 1'b0;
        @(posedge clock); #2;
        @(negedge clock);
        check("rr_q", q_s, 32'h0);
        check("rr_r", r_s, 32'h0);
        check("rr_busy", W'(busy_s), 32'h0);
        check("rr_stall", W'(stall_s), 32'h0);
        @(posedge clock); #2;
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done_s) ndone++;
        end
        check("rr_no_done", W'(ndone), 32'd0);

        // Back-to-back with start held through DONE
        do_div(32'd1234, 32'd5, 1'b1, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("bb1_q", qs, 32'd246);
        check("bb1_r", rs, 32'd4);
        do_div(32'd9, 32'd3, 1'b0, qs, rs, qu, ru, dz, lat, nstall, nbusy);
        check("bb2_q", qs, 32'd3);
        check("bb2_r", rs, 32'd0);
        check("bb2_lat", W'(lat), 32'd33);

        // Randomized operations, checked cycle by cycle by the model
        for (int i = 0; i < 25; i++) begin
            x = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 300));
            case ($urandom_range(0, 3))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(0, 15));
                2:       y = 32'd0 - 32'($urandom_range(1, 16));
                default: y = 32'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h80000000;
            do_div(x, y, 1'($urandom_range(0, 1)), qs, rs, qu, ru, dz, lat, nstall, nbusy);
        end
        @(posedge clock); #2;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_div_seq_ctrl
`default_nettype wire
